// File: rtl/upload_pkg.sv
// Shared constants and FSM encoding for the framed upload path.
package upload_pkg;

  localparam logic [7:0] HDR0  = 8'hAA;
  localparam logic [7:0] HDR1  = 8'h55;
  localparam int         LEN_W = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_SRC  = 3'd3,
    S_LENH = 3'd4,
    S_LENL = 3'd5,
    S_PAY  = 3'd6,
    S_CSUM = 3'd7
  } state_e;

endpackage

// File: rtl/upload_fifo.sv
// Synchronous show-ahead byte FIFO: rdata always presents the head entry.
module upload_fifo #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  wdata,
  input  logic        pop,
  output logic [7:0]  rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/upload_packer.sv
// Buffers a raw byte stream and emits framed packets (AA 55 SRC LEN_H LEN_L payload CSUM)
// when MAX_LEN bytes are queued or the input has been idle for TIMEOUT cycles.
module upload_packer
  import upload_pkg::*;
#(
  parameter int         DEPTH   = 256,
  parameter int         MAX_LEN = 64,
  parameter int         TIMEOUT = 6000,
  parameter logic [7:0] SRC_ID  = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] src_data,
  input  logic       src_valid,
  output logic       src_ready,
  output logic [7:0] usb_upload_data,
  output logic       usb_upload_valid,
  input  logic       usb_upload_ready,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   MAX_CNT  = (AW+1)'(MAX_LEN);

  state_e           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       csum_q, csum_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] pay_cnt_q, pay_cnt_d;
  logic [TW-1:0]    idle_cnt_q, idle_cnt_d;
  logic             overflow_q, overflow_d;

  logic [AW:0] fifo_count;
  logic [7:0]  fifo_rdata;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic        push, hs, trigger;

  upload_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (src_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign src_ready        = !fifo_full;
  assign push             = src_valid && src_ready;
  assign usb_upload_valid = (state_q != S_IDLE);
  assign usb_upload_data  = data_q;
  assign overflow         = overflow_q;
  assign hs               = usb_upload_valid && usb_upload_ready;
  assign trigger = (state_q == S_IDLE) &&
                   ((fifo_count >= MAX_CNT) || (!fifo_empty && idle_cnt_q == IDLE_MAX));

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    csum_d     = csum_q;
    len_d      = len_q;
    pay_cnt_d  = pay_cnt_q;
    fifo_pop   = 1'b0;
    overflow_d = overflow_q || (src_valid && fifo_full);

    if (push || trigger)           idle_cnt_d = '0;
    else if (idle_cnt_q == IDLE_MAX) idle_cnt_d = idle_cnt_q;
    else                           idle_cnt_d = idle_cnt_q + 1'b1;

    // data_q always holds the byte for the state being entered, so each
    // payload byte is popped as it is loaded into the output register.
    case (state_q)
      S_IDLE: if (trigger) begin
        state_d   = S_HDR0;
        data_d    = HDR0;
        csum_d    = SRC_ID;
        pay_cnt_d = '0;
        len_d     = (fifo_count >= MAX_CNT) ? LEN_W'(MAX_LEN) : LEN_W'(fifo_count);
      end
      S_HDR0: if (hs) begin
        state_d = S_HDR1;
        data_d  = HDR1;
      end
      S_HDR1: if (hs) begin
        state_d = S_SRC;
        data_d  = SRC_ID;
      end
      S_SRC: if (hs) begin
        state_d = S_LENH;
        data_d  = len_q[15:8];
        csum_d  = csum_q + len_q[15:8];
      end
      S_LENH: if (hs) begin
        state_d = S_LENL;
        data_d  = len_q[7:0];
        csum_d  = csum_q + len_q[7:0];
      end
      S_LENL: if (hs) begin
        state_d   = S_PAY;
        fifo_pop  = 1'b1;
        data_d    = fifo_rdata;
        csum_d    = csum_q + fifo_rdata;
        pay_cnt_d = LEN_W'(1);
      end
      S_PAY: if (hs) begin
        if (pay_cnt_q == len_q) begin
          state_d = S_CSUM;
          data_d  = csum_q;
        end else begin
          fifo_pop  = 1'b1;
          data_d    = fifo_rdata;
          csum_d    = csum_q + fifo_rdata;
          pay_cnt_d = pay_cnt_q + 1'b1;
        end
      end
      S_CSUM: if (hs) begin
        state_d = S_IDLE;
        data_d  = 8'h00;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      data_q     <= 8'h00;
      csum_q     <= 8'h00;
      len_q      <= '0;
      pay_cnt_q  <= '0;
      idle_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      csum_q     <= csum_d;
      len_q      <= len_d;
      pay_cnt_q  <= pay_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_upload_packer.sv
// Bench for upload_packer: table-driven frames, directed corner sequences and a
// randomized stream, all checked against a queue-based model of the frame format.
module tb_upload_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] usb_upload_data;
  logic       usb_upload_valid;
  logic       usb_upload_ready;
  logic       overflow;

  upload_packer dut (
    .clk              (clk),
    .rst              (rst),
    .src_data         (src_data),
    .src_valid        (src_valid),
    .src_ready        (src_ready),
    .usb_upload_data  (usb_upload_data),
    .usb_upload_valid (usb_upload_valid),
    .usb_upload_ready (usb_upload_ready),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  logic [7:0] in_q[$];   // accepted input bytes not yet seen in a frame
  logic [7:0] out_q[$];  // bytes handed over on the upload interface
  int   last_in_cyc, first_vld_cyc, run, last_run;
  logic stall_prev;
  logic [7:0] stall_data;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (cyc == 150000) begin
      $display("FAIL watchdog: cycle budget exhausted");
      $fatal(1);
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      in_q.delete();
      out_q.delete();
      run        = 0;
      stall_prev = 1'b0;
    end else begin
      if (src_valid && src_ready) begin
        in_q.push_back(src_data);
        last_in_cyc = cyc;
      end
      if (usb_upload_valid) begin
        if (run == 0) first_vld_cyc = cyc;
        run++;
      end else if (run != 0) begin
        last_run = run;
        run      = 0;
      end
      if (stall_prev) begin
        chk("stall_valid", int'(usb_upload_valid), 1);
        chk("stall_data", int'(usb_upload_data), int'(stall_data));
      end
      stall_prev = usb_upload_valid && !usb_upload_ready;
      stall_data = usb_upload_data;
      if (usb_upload_valid && usb_upload_ready) out_q.push_back(usb_upload_data);
    end
  end

  task automatic send(input logic [7:0] b);
    int g = 0;
    @(posedge clk); #1;
    src_valid = 1'b1;
    src_data  = b;
    forever begin
      @(negedge clk);
      if (src_ready) break;
      g++;
      if (g > 5000) begin
        chk("send_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic src_idle();
    @(posedge clk); #1;
    src_valid = 1'b0;
  endtask

  // Pull one frame from the output stream and check it against the model.
  task automatic get_frame(input int exp_len, output int len, output int csum);
    int t, h, l, b, e, sum;
    len  = 0;
    csum = -1;
    t    = 0;
    while (out_q.size() < 5 && t < 7000) begin @(negedge clk); t++; end
    if (out_q.size() < 5) begin
      chk("frame_hdr_timeout", out_q.size(), 5);
      return;
    end
    chk("hdr0", int'(out_q.pop_front()), 'hAA);
    chk("hdr1", int'(out_q.pop_front()), 'h55);
    chk("src_id", int'(out_q.pop_front()), 'h01);
    h   = int'(out_q.pop_front());
    l   = int'(out_q.pop_front());
    len = h * 256 + l;
    if (exp_len >= 0) chk("len", len, exp_len);
    else              chk("len_range", int'(len >= 1 && len <= 64), 1);
    t = 0;
    while (out_q.size() < len + 1 && t < 7000) begin @(negedge clk); t++; end
    if (out_q.size() < len + 1) begin
      chk("frame_body_timeout", out_q.size(), len + 1);
      return;
    end
    sum = 1 + h + l;
    for (int i = 0; i < len; i++) begin
      b = int'(out_q.pop_front());
      e = (in_q.size() > 0) ? int'(in_q.pop_front()) : -1;
      chk("payload", b, e);
      sum += e;
    end
    csum = int'(out_q.pop_front());
    chk("csum", csum, sum & 255);
  endtask

  typedef struct {
    int         n;
    logic [7:0] start;
    logic [7:0] step;
    int         exp_len;
    int         exp_csum;
  } vec_t;

  vec_t tbl[5];
  int   len, cs;
  logic done;

  initial begin
    tbl[0] = '{3,  8'h01, 8'h01, 3,  'h0A};
    tbl[1] = '{1,  8'hFF, 8'h00, 1,  'h01};
    tbl[2] = '{2,  8'hAA, 8'hAB, 2,  'h02};
    tbl[3] = '{64, 8'h80, 8'h00, 64, 'h41};
    tbl[4] = '{64, 8'h00, 8'h01, 64, 'h21};

    rst = 1'b1; src_valid = 1'b0; src_data = 8'h00; usb_upload_ready = 1'b1;
    run = 0; last_run = 0; stall_prev = 1'b0; last_in_cyc = 0; first_vld_cyc = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(usb_upload_valid), 0);
    chk("rst_data", int'(usb_upload_data), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_src_ready", int'(src_ready), 1);

    // Table-driven frames
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < tbl[k].n; i++) begin
        logic [7:0] b;
        b = tbl[k].start + 8'(i) * tbl[k].step;
        send(b);
      end
      src_idle();
      last_run = 0;
      get_frame(tbl[k].exp_len, len, cs);
      chk("tbl_csum", cs, tbl[k].exp_csum);
      if (k == 0) begin
        repeat (2) @(negedge clk);
        chk("flush_latency", first_vld_cyc - last_in_cyc, 6001);
        chk("packet_cycles", last_run, 9);
      end
    end

    // 200 continuous bytes -> 64, 64, 64, then 8 after timeout
    for (int i = 0; i < 200; i++) send(8'(i));
    src_idle();
    get_frame(64, len, cs);
    get_frame(64, len, cs);
    get_frame(64, len, cs);
    get_frame(8, len, cs);

    // Input continues during the packet: LEN unaffected, new bytes follow
    for (int i = 0; i < 74; i++) send(8'(i * 3));
    src_idle();
    get_frame(64, len, cs);
    get_frame(10, len, cs);

    // Random backpressure during a 64-byte packet
    for (int i = 0; i < 64; i++) send(8'($urandom_range(0, 255)));
    src_idle();
    done = 1'b0;
    fork
      begin get_frame(64, len, cs); done = 1'b1; end
      begin
        while (!done) begin
          @(posedge clk); #1 usb_upload_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #1 usb_upload_ready = 1'b1;

    // Random stream with random gaps and random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send(8'($urandom_range(0, 255)));
          if ($urandom_range(0, 3) == 0) begin
            src_idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
          end
        end
        src_idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1 usb_upload_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #1 usb_upload_ready = 1'b1;
    for (int g = 0; g < 20 && in_q.size() > 0; g++) get_frame(-1, len, cs);
    chk("rand_drained", in_q.size(), 0);
    repeat (2) @(negedge clk);
    chk("rand_no_extra", out_q.size(), 0);

    // 300 bytes with the output stalled: fill to 256, overflow, then drain
    @(posedge clk); #1 usb_upload_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1 src_valid = 1'b1; src_data = 8'(i);
    end
    @(posedge clk); #1 src_valid = 1'b0;
    @(negedge clk);
    chk("full_src_ready", int'(src_ready), 0);
    chk("full_no_overflow_yet", int'(overflow), 0);
    chk("full_accepted", in_q.size(), 256);
    for (int i = 256; i < 300; i++) begin
      @(posedge clk); #1 src_valid = 1'b1; src_data = 8'(i);
    end
    @(posedge clk); #1 src_valid = 1'b0;
    @(negedge clk);
    chk("overflow_set", int'(overflow), 1);
    chk("overflow_dropped", in_q.size(), 256);
    usb_upload_ready = 1'b1;
    for (int p = 0; p < 4; p++) get_frame(64, len, cs);
    chk("overflow_sticky", int'(overflow), 1);
    chk("drain_src_ready", int'(src_ready), 1);

    // Reset while in PAY abandons the frame and empties the FIFO
    for (int i = 0; i < 64; i++) send(8'(i + 7));
    src_idle();
    for (int t = 0; t < 200 && out_q.size() < 8; t++) @(negedge clk);
    chk("reached_pay", int'(out_q.size() >= 8), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_pay_valid", int'(usb_upload_valid), 0);
    chk("rst_pay_overflow", int'(overflow), 0);
    rst = 1'b0;
    repeat (6100) @(negedge clk);
    chk("rst_fifo_empty", out_q.size(), 0);
    send(8'h5A);
    src_idle();
    get_frame(1, len, cs);
    chk("rst_fresh_csum", cs, 'h5C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
